// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, display widths, default timing constants.
package stopwatch_pkg;

    localparam int unsigned MIN_W                   = 7;
    localparam int unsigned SEC_W                   = 7;
    localparam int unsigned SEC_MAX                 = 59;
    localparam int unsigned DEFAULT_TICK_DIV        = 50_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEFAULT_MAX_MINUTES     = 99;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_FULL    = 2'd3
    } sw_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_controller_debouncer.sv
// button_debouncer: 2-FF synchroniser, stability counter and rising-edge pulse for one raw button.
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic pressed_pulse
);

    localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level;
    logic [CNT_W-1:0] stable_cnt;

    // Accept a new level only after it has differed from the accepted one for DEBOUNCE_CYCLES cycles;
    // pulse once when the accepted level goes high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q        <= '0;
            level         <= 1'b0;
            stable_cnt    <= '0;
            pressed_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], btn_in};
            pressed_pulse <= 1'b0;
            if (sync_q[1] != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level         <= sync_q[1];
                    stable_cnt    <= '0;
                    pressed_pulse <= sync_q[1];
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: button debouncing, start/pause/clear FSM, 1 Hz prescaler and mm:ss count.
// Optional lap hold is compiled in with `define LAP_HOLD_EN.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned MAX_MINUTES     = DEFAULT_MAX_MINUTES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_start_stop,
    input  logic             btn_clear,
    input  logic             btn_lap,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             tick,
    output logic             overflow
);

    localparam int unsigned      PRE_W     = cnt_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_LIMIT = MIN_W'(MAX_MINUTES);
    localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(SEC_MAX);

    sw_state_t        state, state_next;
    logic [PRE_W-1:0] prescaler;
    logic [MIN_W-1:0] min_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic             cmd_start_stop, cmd_clear;
    logic             tick_now, at_max;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
        .clock         (clock),
        .reset         (reset),
        .btn_in        (btn_start_stop),
        .pressed_pulse (cmd_start_stop)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clock         (clock),
        .reset         (reset),
        .btn_in        (btn_clear),
        .pressed_pulse (cmd_clear)
    );

    assign tick_now = (state == ST_RUNNING) && (prescaler == PRE_LAST);
    assign at_max   = (min_cnt == MIN_LIMIT) && (sec_cnt == SEC_LAST);

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // FSM next state: clear overrides everything; saturation beats a coincident start_stop.
    always_comb begin
        state_next = state;
        if (cmd_clear) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:    if (cmd_start_stop) state_next = ST_RUNNING;
                ST_RUNNING: begin
                    if (tick_now && at_max)  state_next = ST_FULL;
                    else if (cmd_start_stop) state_next = ST_PAUSED;
                end
                ST_PAUSED:  if (cmd_start_stop) state_next = ST_RUNNING;
                ST_FULL:    state_next = ST_FULL;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        running  = (state == ST_RUNNING);
        overflow = (state == ST_FULL);
    end

    // Prescaler and mm:ss count; tick is registered so it coincides with the count update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            min_cnt   <= '0;
            sec_cnt   <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (cmd_clear) begin
                prescaler <= '0;
                min_cnt   <= '0;
                sec_cnt   <= '0;
            end else if (tick_now) begin
                prescaler <= '0;
                tick      <= 1'b1;
                if (!at_max) begin
                    if (sec_cnt == SEC_LAST) begin
                        sec_cnt <= '0;
                        min_cnt <= min_cnt + MIN_W'(1);
                    end else begin
                        sec_cnt <= sec_cnt + SEC_W'(1);
                    end
                end
            end else if (state == ST_RUNNING) begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic             cmd_lap;
    logic             hold_on;
    logic [MIN_W-1:0] held_min;
    logic [SEC_W-1:0] held_sec;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clock         (clock),
        .reset         (reset),
        .btn_in        (btn_lap),
        .pressed_pulse (cmd_lap)
    );

    // Lap toggles a display freeze in RUNNING/PAUSED; the live count keeps going underneath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_on  <= 1'b0;
            held_min <= '0;
            held_sec <= '0;
        end else if (cmd_clear) begin
            hold_on <= 1'b0;
        end else if (cmd_lap && (state == ST_RUNNING || state == ST_PAUSED)) begin
            hold_on  <= ~hold_on;
            held_min <= min_cnt;
            held_sec <= sec_cnt;
        end
    end

    assign minutes = hold_on ? held_min : min_cnt;
    assign seconds = hold_on ? held_sec : sec_cnt;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
    assign minutes        = min_cnt;
    assign seconds        = sec_cnt;
`endif

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller (TICK_DIV=4, DEBOUNCE_CYCLES=2, MAX_MINUTES=1).
module tb_stopwatch_controller;

    typedef struct {
        logic [6:0] m;
        logic [6:0] s;
        logic       run;
        logic       ovf;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic [6:0] minutes, seconds;
    logic       running, tick, overflow;

    int   compared = 0;
    int   mismatched = 0;
    exp_t exp_q[$];

    stopwatch_controller #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (2),
        .MAX_MINUTES     (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .btn_lap        (btn_lap),
        .minutes        (minutes),
        .seconds        (seconds),
        .running        (running),
        .tick           (tick),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    // Monitor: every tick pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (!reset && tick) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_tick: got %0d:%0d run=%0b ovf=%0b, required no tick",
                         minutes, seconds, running, overflow);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (minutes !== e.m || seconds !== e.s || running !== e.run || overflow !== e.ovf) begin
                    mismatched++;
                    $display("FAIL tick_output: got %0d:%0d run=%0b ovf=%0b, required %0d:%0d run=%0b ovf=%0b",
                             minutes, seconds, running, overflow, e.m, e.s, e.run, e.ovf);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_outputs(input string name, input int m, input int s, input int run, input int ovf);
        check({name, "_minutes"},  int'(minutes),  m);
        check({name, "_seconds"},  int'(seconds),  s);
        check({name, "_running"},  int'(running),  run);
        check({name, "_overflow"}, int'(overflow), ovf);
    endtask

    function automatic void push_exp(input int m, input int s, input bit run, input bit ovf);
        exp_t e;
        e.m = 7'(m); e.s = 7'(s); e.run = run; e.ovf = ovf;
        exp_q.push_back(e);
    endfunction

    // Live running ticks for total elapsed seconds first..last.
    function automatic void push_run(input int first, input int last);
        for (int i = first; i <= last; i++) push_exp(i / 60, i % 60, 1'b1, 1'b0);
    endfunction

    // Press: drive on a negedge, hold 10 cycles, release, let the release settle 6 cycles.
    task automatic press(input bit ss, input bit clr);
        @(negedge clock);
        btn_start_stop = ss;
        btn_clear      = clr;
        repeat (10) @(negedge clock);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        bit seen;

        // Reset state
        repeat (3) @(negedge clock);
        check_outputs("reset", 0, 0, 0, 0);
        check("reset_tick", int'(tick), 0);
        reset = 1'b0;

        // One-cycle glitch must be rejected
        @(negedge clock);
        btn_start_stop = 1'b1;
        @(negedge clock);
        btn_start_stop = 1'b0;
        repeat (10) @(negedge clock);
        check_outputs("glitch", 0, 0, 0, 0);

        // Run 0:00 -> 1:59, then saturate into FULL on the 120th tick
        push_run(1, 119);
        push_exp(1, 59, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("start_running", int'(running), 1);
        wait_empty("run_to_full", 700);
        repeat (3) @(negedge clock);
        check_outputs("full", 1, 59, 0, 1);
        press(1'b1, 1'b0);
        repeat (8) @(negedge clock);
        check_outputs("full_ss_ignored", 1, 59, 0, 1);
        press(1'b0, 1'b1);
        check_outputs("full_clear", 0, 0, 0, 0);

        // Pause two cycles after a tick, resume, next tick two cycles after running rises
        push_run(1, 4);
        press(1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = tick;
        end
        check("pause_sync_tick_seen", int'(seen), 1);
        @(posedge clock);
        @(negedge clock);
        btn_start_stop = 1'b1;
        repeat (10) @(negedge clock);
        btn_start_stop = 1'b0;
        repeat (10) @(negedge clock);
        check_outputs("paused", 0, 4, 0, 0);
        push_run(5, 8);
        fork
            press(1'b1, 1'b0);
            begin
                n = 0;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clock);
                    seen = running;
                end
                check("resume_running", int'(seen), 1);
                seen = 1'b0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clock);
                    n++;
                    seen = tick;
                end
                check("resume_to_tick_cycles", n, 2);
            end
        join
        press(1'b0, 1'b1);
        check_outputs("pause_clear", 0, 0, 0, 0);
        check("pause_queue_drained", exp_q.size(), 0);

        // clear and start_stop together in IDLE: clear wins
        press(1'b1, 1'b1);
        repeat (10) @(negedge clock);
        check_outputs("clear_beats_start", 0, 0, 0, 0);

        // Reset in the middle of RUNNING
        push_run(1, 2);
        press(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_outputs("mid_run_reset", 0, 0, 0, 0);
        check("mid_run_reset_tick", int'(tick), 0);
        check("mid_run_queue_drained", exp_q.size(), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_outputs("after_reset", 0, 0, 0, 0);

        // Lap at 0:05 for 10 ticks, release shows 0:15 (live throughout when lap hold is absent)
        push_run(1, 5);
        for (int i = 6; i <= 15; i++) begin
`ifdef LAP_HOLD_EN
            push_exp(0, 5, 1'b1, 1'b0);
`else
            push_exp(0, i, 1'b1, 1'b0);
`endif
        end
        push_run(16, 16);
        @(negedge clock);
        btn_start_stop = 1'b1;
        fork
            begin
                repeat (10) @(negedge clock);
                btn_start_stop = 1'b0;
            end
            begin
                repeat (21) @(negedge clock);
                btn_lap = 1'b1;
                repeat (4) @(negedge clock);
                btn_lap = 1'b0;
                repeat (36) @(negedge clock);
                btn_lap = 1'b1;
                repeat (4) @(negedge clock);
                btn_lap = 1'b0;
                @(negedge clock);
                check("lap_release_minutes", int'(minutes), 0);
                check("lap_release_seconds", int'(seconds), 15);
            end
        join
        press(1'b0, 1'b1);
        check_outputs("lap_clear", 0, 0, 0, 0);
        wait_empty("lap", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
